// File: rtl/Global.sv
// Machine-wide scalar types shared by every pipeline stage.
package Global;

    typedef logic [31:0] size_t;

endpackage

// File: rtl/IR.sv
// Instruction-level types: register indices and the issued-operand bundle.
package IR;

    localparam int unsigned NUM_REGS = 32;

    typedef logic [4:0] reg_t;

    typedef struct packed {
        Global::size_t op_a;
        Global::size_t op_b;
        reg_t          dest;
        logic          wen;
    } issue_t;

endpackage

// File: rtl/scoreboard.sv
// Pending-write bit per architectural register; x0 is never tracked and a
// same-cycle set beats a clear so a freshly issued writer is not lost.
module scoreboard
    import IR::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        set_en,
    input  reg_t        set_idx,
    input  logic        clr_en,
    input  reg_t        clr_idx,
    output logic [31:0] busy
);

    logic [31:0] r_busy;
    logic [31:0] w_set_mask;
    logic [31:0] w_clr_mask;
    logic [31:0] w_busy_next;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (set_en && set_idx != '0) w_set_mask[set_idx] = 1'b1;
        if (clr_en && clr_idx != '0) w_clr_mask[clr_idx] = 1'b1;
        w_busy_next    = (r_busy & ~w_clr_mask) | w_set_mask;
        w_busy_next[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only; reset clears all 32 bits as plain flops.
    always_ff @(posedge clk) begin
        if (rst) r_busy <= '0;
        else     r_busy <= w_busy_next;
    end

    assign busy = r_busy;

endmodule

// File: rtl/operand_issue.sv
// Operand-fetch/issue stage: checks RAW and WAW hazards against the scoreboard,
// selects operands (optionally bypassing writeback) and holds one issued entry.
module operand_issue
    import Global::*;
    import IR::*;
#(
    parameter bit FORWARD = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  reg_t        dec_src_a,
    input  reg_t        dec_src_b,
    input  reg_t        dec_dest,
    input  logic        dec_wen,
    output reg_t        rf_src_a,
    output reg_t        rf_src_b,
    input  size_t       rf_reg_a,
    input  size_t       rf_reg_b,
    output logic        ex_valid,
    input  logic        ex_ready,
    output size_t       ex_op_a,
    output size_t       ex_op_b,
    output reg_t        ex_dest,
    output logic        ex_wen,
    input  logic        wb_load,
    input  reg_t        wb_dest,
    input  size_t       wb_data,
    output logic [31:0] sb_busy
);

    logic [31:0] w_busy;
    logic        w_hit_a;
    logic        w_hit_b;
    logic        w_pend_a;
    logic        w_pend_b;
    logic        w_waw;
    logic        w_accept;
    issue_t      w_issue;
    logic        r_ex_valid;
    issue_t      r_ex;

    assign rf_src_a = dec_src_a;
    assign rf_src_b = dec_src_b;

    assign w_hit_a = wb_load && (wb_dest == dec_src_a);
    assign w_hit_b = wb_load && (wb_dest == dec_src_b);

    always_comb begin
        w_pend_a = (dec_src_a != '0) && w_busy[dec_src_a] && !(FORWARD && w_hit_a);
        w_pend_b = (dec_src_b != '0) && w_busy[dec_src_b] && !(FORWARD && w_hit_b);
        // A writeback retiring the old writer this cycle removes the WAW conflict
        // regardless of forwarding, since the new set overrides the clear.
        w_waw    = dec_wen && (dec_dest != '0) && w_busy[dec_dest]
                   && !(wb_load && wb_dest == dec_dest);
        dec_ready = (!r_ex_valid || ex_ready) && !w_pend_a && !w_pend_b && !w_waw;
        w_accept  = dec_valid && dec_ready;
    end

    always_comb begin
        w_issue = '0;
        if (dec_src_a == '0)          w_issue.op_a = '0;
        else if (FORWARD && w_hit_a)  w_issue.op_a = wb_data;
        else                          w_issue.op_a = rf_reg_a;
        if (dec_src_b == '0)          w_issue.op_b = '0;
        else if (FORWARD && w_hit_b)  w_issue.op_b = wb_data;
        else                          w_issue.op_b = rf_reg_b;
        w_issue.dest = dec_dest;
        w_issue.wen  = dec_wen && (dec_dest != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid <= 1'b0;
            r_ex       <= '0;
        end else if (w_accept) begin
            r_ex_valid <= 1'b1;
            r_ex       <= w_issue;
        end else if (ex_ready) begin
            r_ex_valid <= 1'b0;
        end
    end

    scoreboard u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_en  (w_accept && w_issue.wen),
        .set_idx (dec_dest),
        .clr_en  (wb_load),
        .clr_idx (wb_dest),
        .busy    (w_busy)
    );

    assign ex_valid = r_ex_valid;
    assign ex_op_a  = r_ex.op_a;
    assign ex_op_b  = r_ex.op_b;
    assign ex_dest  = r_ex.dest;
    assign ex_wen   = r_ex.wen;
    assign sb_busy  = w_busy;

endmodule

// File: tb/tb_operand_issue.sv
// Directed bench for operand_issue: a per-cycle vector table on the forwarding
// variant, then a hand sequence contrasting forwarding against stalling.
module tb_operand_issue;
    import Global::*;
    import IR::*;

    logic  clk;
    logic  rst;
    logic  dec_valid;
    reg_t  dec_src_a, dec_src_b, dec_dest;
    logic  dec_wen;
    size_t rf_reg_a, rf_reg_b;
    logic  ex_ready;
    logic  wb_load;
    reg_t  wb_dest;
    size_t wb_data;

    logic        f_rdy, f_ev, f_ew;
    reg_t        f_rfa, f_rfb, f_ed;
    size_t       f_a, f_b;
    logic [31:0] f_sb;

    logic        s_rdy, s_ev, s_ew;
    reg_t        s_rfa, s_rfb, s_ed;
    size_t       s_a, s_b;
    logic [31:0] s_sb;

    operand_issue #(.FORWARD(1'b1)) dut_f (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(f_rdy),
        .dec_src_a(dec_src_a), .dec_src_b(dec_src_b), .dec_dest(dec_dest), .dec_wen(dec_wen),
        .rf_src_a(f_rfa), .rf_src_b(f_rfb), .rf_reg_a(rf_reg_a), .rf_reg_b(rf_reg_b),
        .ex_valid(f_ev), .ex_ready(ex_ready), .ex_op_a(f_a), .ex_op_b(f_b),
        .ex_dest(f_ed), .ex_wen(f_ew), .wb_load(wb_load), .wb_dest(wb_dest),
        .wb_data(wb_data), .sb_busy(f_sb)
    );

    operand_issue #(.FORWARD(1'b0)) dut_s (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(s_rdy),
        .dec_src_a(dec_src_a), .dec_src_b(dec_src_b), .dec_dest(dec_dest), .dec_wen(dec_wen),
        .rf_src_a(s_rfa), .rf_src_b(s_rfb), .rf_reg_a(rf_reg_a), .rf_reg_b(rf_reg_b),
        .ex_valid(s_ev), .ex_ready(ex_ready), .ex_op_a(s_a), .ex_op_b(s_b),
        .ex_dest(s_ed), .ex_wen(s_ew), .wb_load(wb_load), .wb_dest(wb_dest),
        .wb_data(wb_data), .sb_busy(s_sb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, dv;
        logic [4:0]  sa, sb, d;
        logic        w;
        logic [31:0] ra, rb;
        logic        exr, wbl;
        logic [4:0]  wbd;
        logic [31:0] wbdat;
        logic        rdy, ev;
        logic [31:0] a, b;
        logic [4:0]  ed;
        logic        ew;
        logic [31:0] sbx;
    } vec_t;

    function automatic vec_t mk(
        input logic rst_i, input logic dv, input logic [4:0] sa, input logic [4:0] sb,
        input logic [4:0] d, input logic w, input logic [31:0] ra, input logic [31:0] rb,
        input logic exr, input logic wbl, input logic [4:0] wbd, input logic [31:0] wbdat,
        input logic rdy, input logic ev, input logic [31:0] a, input logic [31:0] b,
        input logic [4:0] ed, input logic ew, input logic [31:0] sbx);
        vec_t t;
        t.rst = rst_i; t.dv = dv; t.sa = sa; t.sb = sb; t.d = d; t.w = w;
        t.ra = ra; t.rb = rb; t.exr = exr; t.wbl = wbl; t.wbd = wbd; t.wbdat = wbdat;
        t.rdy = rdy; t.ev = ev; t.a = a; t.b = b; t.ed = ed; t.ew = ew; t.sbx = sbx;
        return t;
    endfunction

    task automatic drive(input logic r, input logic dv, input logic [4:0] sa, input logic [4:0] sb,
                         input logic [4:0] d, input logic w, input logic [31:0] ra,
                         input logic [31:0] rb, input logic exr, input logic wbl,
                         input logic [4:0] wbd, input logic [31:0] wbdat);
        rst = r; dec_valid = dv; dec_src_a = sa; dec_src_b = sb; dec_dest = d; dec_wen = w;
        rf_reg_a = ra; rf_reg_b = rb; ex_ready = exr; wb_load = wbl; wb_dest = wbd; wb_data = wbdat;
    endtask

    vec_t vecs[18];

    initial begin
        // rst dv sa sb d w  ra rb  exr wbl wbd wbdat | rdy ev a b ed ew sb
        vecs[0]  = mk(1,0, 0,0,0,0, 0,0, 0, 0,0,0,            0, 0, 0,0,0,0, 32'h0);
        vecs[1]  = mk(0,1, 1,2,5,1, 10,20, 1, 0,0,0,          1, 1, 10,20,5,1, 32'h20);
        vecs[2]  = mk(0,1, 5,0,6,1, 0,99, 1, 0,0,0,           0, 0, 0,0,0,0, 32'h20);
        vecs[3]  = mk(0,1, 5,0,6,1, 0,99, 1, 1,5,32'h1234,    1, 1, 32'h1234,0,6,1, 32'h40);
        vecs[4]  = mk(0,1, 1,2,8,1, 3,4, 0, 0,0,0,            0, 1, 32'h1234,0,6,1, 32'h40);
        vecs[5]  = mk(0,1, 1,2,8,1, 3,4, 0, 0,0,0,            0, 1, 32'h1234,0,6,1, 32'h40);
        vecs[6]  = mk(0,1, 1,2,8,1, 3,4, 0, 0,0,0,            0, 1, 32'h1234,0,6,1, 32'h40);
        vecs[7]  = mk(0,1, 1,2,8,1, 3,4, 1, 0,0,0,            1, 1, 3,4,8,1, 32'h140);
        vecs[8]  = mk(0,1, 0,0,7,1, 55,55, 1, 0,0,0,          1, 1, 0,0,7,1, 32'h1C0);
        vecs[9]  = mk(0,1, 3,4,7,1, 11,12, 1, 1,7,77,         1, 1, 11,12,7,1, 32'h1C0);
        vecs[10] = mk(0,1, 9,10,8,1, 0,0, 1, 0,0,0,           0, 0, 0,0,0,0, 32'h1C0);
        vecs[11] = mk(0,1, 0,0,0,1, 32'hFFFF,32'hFFFF, 1, 0,0,0, 1, 1, 0,0,0,0, 32'h1C0);
        vecs[12] = mk(0,0, 0,0,0,0, 0,0, 1, 1,3,5,            1, 0, 0,0,0,0, 32'h1C0);
        vecs[13] = mk(0,0, 0,0,0,0, 0,0, 1, 1,0,5,            1, 0, 0,0,0,0, 32'h1C0);
        vecs[14] = mk(0,1, 0,0,5,1, 0,0, 1, 1,6,0,            1, 1, 0,0,5,1, 32'h1A0);
        vecs[15] = mk(0,0, 0,0,0,0, 0,0, 0, 1,7,0,            0, 1, 0,0,5,1, 32'h120);
        vecs[16] = mk(1,1, 0,0,9,1, 0,0, 1, 1,5,0,            0, 0, 0,0,0,0, 32'h0);
        vecs[17] = mk(0,1, 0,0,1,1, 0,0, 1, 0,0,0,            1, 1, 0,0,1,1, 32'h2);

        drive(1,0,0,0,0,0,0,0,0,0,0,0);
        @(posedge clk);

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].dv, vecs[i].sa, vecs[i].sb, vecs[i].d, vecs[i].w,
                  vecs[i].ra, vecs[i].rb, vecs[i].exr, vecs[i].wbl, vecs[i].wbd, vecs[i].wbdat);
            #1;
            check($sformatf("v%0d rf_src_a", i), 32'(f_rfa), 32'(vecs[i].sa));
            check($sformatf("v%0d rf_src_b", i), 32'(f_rfb), 32'(vecs[i].sb));
            if (!vecs[i].rst) check($sformatf("v%0d dec_ready", i), 32'(f_rdy), 32'(vecs[i].rdy));
            @(posedge clk);
            #1;
            check($sformatf("v%0d ex_valid", i), 32'(f_ev), 32'(vecs[i].ev));
            check($sformatf("v%0d sb_busy", i), f_sb, vecs[i].sbx);
            if (vecs[i].rst || vecs[i].ev) begin
                check($sformatf("v%0d ex_op_a", i), f_a, vecs[i].a);
                check($sformatf("v%0d ex_op_b", i), f_b, vecs[i].b);
                check($sformatf("v%0d ex_dest", i), 32'(f_ed), 32'(vecs[i].ed));
                check($sformatf("v%0d ex_wen", i), 32'(f_ew), 32'(vecs[i].ew));
            end
        end

        // Forwarding versus stalling on the same RAW-with-writeback cycle.
        @(negedge clk);
        drive(1,0,0,0,0,0,0,0,1,0,0,0);
        @(posedge clk); #1;
        check("s reset sb_busy", s_sb, 32'h0);
        check("s reset ex_valid", 32'(s_ev), 32'h0);

        @(negedge clk);
        drive(0,1,1,2,5,1,10,20,1,0,0,0);
        #1;
        check("s first dec_ready", 32'(s_rdy), 32'h1);
        @(posedge clk); #1;
        check("s first ex_op_a", s_a, 32'd10);
        check("s first sb_busy", s_sb, 32'h20);

        @(negedge clk);
        drive(0,1,5,0,6,1,0,0,1,1,5,32'h1234);
        #1;
        check("f fwd dec_ready", 32'(f_rdy), 32'h1);
        check("s stall dec_ready", 32'(s_rdy), 32'h0);
        @(posedge clk); #1;
        check("f fwd ex_op_a", f_a, 32'h1234);
        check("s stall ex_valid", 32'(s_ev), 32'h0);
        check("s stall sb_busy", s_sb, 32'h0);

        // Register file now holds the written value.
        @(negedge clk);
        drive(0,1,5,0,6,1,32'h1234,0,1,0,0,0);
        #1;
        check("s late dec_ready", 32'(s_rdy), 32'h1);
        check("f waw dec_ready", 32'(f_rdy), 32'h0);
        @(posedge clk); #1;
        check("s late ex_valid", 32'(s_ev), 32'h1);
        check("s late ex_op_a", s_a, 32'h1234);
        check("s late ex_dest", 32'(s_ed), 32'd6);
        check("s late sb_busy", s_sb, 32'h40);

        @(negedge clk);
        drive(0,0,0,0,0,0,0,0,1,0,0,0);
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/operand_issue.md
OPERAND_ISSUE -- requirements
Module: operand_issue

Interface
REQ-001 SHALL have parameter FORWARD, default 1: 1 = bypass same-cycle writeback data to operands; 0 = stall until the register file holds the value.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 dec_valid  in  1  decoded instruction present.
REQ-006 dec_ready  out  1  instruction accepted this cycle when high with dec_valid.
REQ-007 dec_src_a, dec_src_b  in  IR::reg_t  source register indices.
REQ-008 dec_dest  in  IR::reg_t  destination index; dec_wen  in  1  instruction writes dec_dest.
REQ-009 rf_src_a, rf_src_b  out  IR::reg_t  register-file read addresses.
REQ-010 rf_reg_a, rf_reg_b  in  Global::size_t  register-file read data, combinational, x0 reads 0.
REQ-011 ex_valid  out  1; ex_ready  in  1  execute-side handshake.
REQ-012 ex_op_a, ex_op_b  out  Global::size_t; ex_dest  out  IR::reg_t; ex_wen  out  1  issued operands and destination.
REQ-013 wb_load  in  1; wb_dest  in  IR::reg_t; wb_data  in  Global::size_t  writeback, identical to the register-file write port.
REQ-014 sb_busy  out  32  scoreboard pending bits, bit 0 always 0.

Function
REQ-015 rf_src_a/rf_src_b SHALL equal dec_src_a/dec_src_b combinationally.
REQ-016 src_x pending = src_x != 0 and sb_busy[src_x], but with FORWARD=1 NOT pending when wb_load && wb_dest == src_x.
REQ-017 WAW hazard = dec_wen, dec_dest != 0, sb_busy[dec_dest], and not (wb_load && wb_dest == dec_dest).
REQ-018 dec_ready = (!ex_valid || ex_ready) && !pending_a && !pending_b && !WAW; SHALL NOT depend on dec_valid.
REQ-019 Operand select per source: 0 if index 0; else wb_data if FORWARD and wb_load && wb_dest == index; else rf_reg_x.
REQ-020 On accept: next edge ex_valid <= 1, ex_op_a/b <= selected operands, ex_dest <= dec_dest, ex_wen <= dec_wen && dec_dest != 0; latency exactly one cycle.
REQ-021 ex_valid && ex_ready without accept: ex_valid <= 0 at next edge.
REQ-022 While ex_valid && !ex_ready: all ex_* outputs SHALL hold stable.
REQ-023 On accept with dec_wen && dec_dest != 0: sb_busy[dec_dest] <= 1.
REQ-024 wb_load && wb_dest != 0: sb_busy[wb_dest] <= 0.
REQ-025 Set and clear of the same bit in one cycle: set wins.
REQ-026 Writes to or reads of x0 SHALL never set, stall on, or clear any scoreboard bit.
REQ-027 wb_load for a non-pending register SHALL be harmless: the bit stays 0.

Reset
REQ-028 While rst is high at an edge: ex_valid, ex_wen, ex_dest, ex_op_a, ex_op_b and sb_busy SHALL become 0.
REQ-029 During rst, accept and writeback SHALL NOT update state.
REQ-030 Reset mid-operation SHALL discard any held ex entry and all pending bits.
REQ-031 dec_ready SHALL be valid combinationally in the reset cycle; its state is ignored by the bench.

Structure
REQ-032 Global::size_t and IR::reg_t SHALL be reused; a new IR::issue_t struct {op_a, op_b, dest, wen} SHALL be added to package IR for the ex_* bundle.
REQ-033 The pending-bit array with set/clear priority SHALL be a sub-module named scoreboard.

Verification
REQ-034 Issue x5 <- (x1, x2) with rf 10/20, ex_ready=1 -> next cycle ex_op_a=10, ex_op_b=20, ex_dest=5, sb_busy[5]=1.
REQ-035 Next instruction reads x5 with x5 pending and no writeback -> dec_ready=0; wb_load x5=0x1234 in the same cycle -> FORWARD=1 accepts with ex_op_a=0x1234; FORWARD=0 accepts one cycle later.
REQ-036 ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* unchanged and dec_ready=0; ex_ready=1 -> the next instruction issues.
REQ-037 Issue writing x7 while wb_load clears x7 in the same cycle -> sb_busy[7]=1 afterwards.
REQ-038 Write to x0 and read of x0 with sb empty -> sb_busy=0, op=0, no stall.
REQ-039 Assert rst with ex_valid=1 and sb_busy=0x00000120 -> next cycle ex_valid=0 and sb_busy=0.
